// File: rtl/msg_log_buf.sv
// Circular capture buffer for a stream of words, replayed oldest-first over a
// valid/ready stream on request, with drop/overwrite handling when full.
module msg_log_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int OVWR  = 0,
  parameter int CNTW  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           dat,
  input  logic                       disp,
  input  logic                       clr,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [WIDTH-1:0]           out_dat,
  output logic                       out_last,
  output logic                       done,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic [CNTW-1:0]            drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    S_IDLE,
    S_DUMP
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [CW-1:0]    count_d;
  logic [CNTW-1:0]  drop_d;
  logic             out_vld_d, out_last_d, done_d;
  logic [WIDTH-1:0] out_dat_d;
  logic             mem_we;
  logic             drop_inc;

  logic [WIDTH-1:0] mem [DEPTH];

  assign busy = (state_q == S_DUMP);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned; otherwise a latch is inferred.
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    rd_ptr_d   = rd_ptr_q;
    rem_d      = rem_q;
    count_d    = count;
    drop_d     = drop_cnt;
    out_vld_d  = out_vld;
    out_last_d = out_last;
    out_dat_d  = out_dat;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    drop_inc   = 1'b0;

    if (clr) begin
      // Flush wins over any write or replay request in the same cycle.
      state_d    = S_IDLE;
      head_d     = '0;
      tail_d     = '0;
      rem_d      = '0;
      count_d    = '0;
      drop_d     = '0;
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr) begin
            if (!full) begin
              mem_we  = 1'b1;
              tail_d  = tail_q + AW'(1);
              count_d = count + CW'(1);
            end else if (OVWR != 0) begin
              mem_we   = 1'b1;
              tail_d   = tail_q + AW'(1);
              head_d   = head_q + AW'(1);
              drop_inc = 1'b1;
            end else begin
              drop_inc = 1'b1;
            end
          end
          // Snapshot uses the pre-write occupancy, so a same-cycle write is not replayed.
          if (disp) begin
            if (count != '0) begin
              state_d    = S_DUMP;
              out_vld_d  = 1'b1;
              out_dat_d  = mem[head_q];
              out_last_d = (count == CW'(1));
              rd_ptr_d   = head_q + AW'(1);
              rem_d      = count - CW'(1);
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_DUMP: begin
          if (wr) drop_inc = 1'b1;
          if (out_vld && out_rdy) begin
            if (out_last) begin
              state_d    = S_IDLE;
              out_vld_d  = 1'b0;
              out_last_d = 1'b0;
              done_d     = 1'b1;
            end else begin
              out_dat_d  = mem[rd_ptr_q];
              out_last_d = (rem_q == CW'(1));
              rd_ptr_d   = rd_ptr_q + AW'(1);
              rem_d      = rem_q - CW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (drop_inc && (drop_cnt != '1)) drop_d = drop_cnt + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      rd_ptr_q <= '0;
      rem_q    <= '0;
      count    <= '0;
      full     <= 1'b0;
      drop_cnt <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_dat  <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      rd_ptr_q <= rd_ptr_d;
      rem_q    <= rem_d;
      count    <= count_d;
      full     <= (count_d == CW'(DEPTH));
      drop_cnt <= drop_d;
      out_vld  <= out_vld_d;
      out_last <= out_last_d;
      out_dat  <= out_dat_d;
      done     <= done_d;
    end
  end

  // NOTE: storage has no reset; entries outside head..tail are never read, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (mem_we) mem[tail_q] <= dat;
  end

endmodule

// File: doc/msg_log_buf.md
Name: msg_log_buf

Overview:
- Parametrised successor to the byte-capture memory used in the lab01 bench.
- Accepts a stream of WIDTH-bit words on a write strobe and stores them in a DEPTH-entry circular buffer.
- On a display request, replays the buffered contents oldest-first over a valid/ready stream.
- Adds full/overflow handling (drop-new or overwrite-oldest), clear, occupancy and drop counters, and back-pressured readout.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 16, buffer entries; power of two, minimum 2
OVWR, 0, full policy: 0 = drop new writes, 1 = overwrite oldest entry
CNTW, 16, width of drop counter

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
wr  in  1  write strobe; dat captured when high
dat  in  WIDTH  write data
disp  in  1  single-cycle request to replay buffer contents
clr  in  1  synchronous flush of buffer and drop counter
out_vld  out  1  replay beat valid
out_rdy  in  1  downstream ready
out_dat  out  WIDTH  replay data
out_last  out  1  high with the final beat of a replay
done  out  1  one-cycle pulse when a replay completes
busy  out  1  high while in DUMP
count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
drop_cnt  out  CNTW  writes dropped or entries overwritten; saturates at all-ones

Behaviour:
- Reset (rst=1 at a clk edge): head=tail=0, count=0, state=IDLE, drop_cnt=0. Outputs out_vld=0, out_last=0, out_dat=0, done=0, busy=0, full=0. Memory contents undefined and never observable.
- Write in IDLE, not full: mem[tail]<=dat; tail+1 mod DEPTH; count+1. Visible in count the next cycle.
- Write in IDLE, full, OVWR=0: write discarded, drop_cnt+1.
- Write in IDLE, full, OVWR=1: mem[tail]<=dat, head and tail both advance, count stays DEPTH, drop_cnt+1.
- Write while in DUMP: always discarded, drop_cnt+1. Buffer is frozen during replay.
- drop_cnt saturates at 2^CNTW-1 and never wraps.
- FSM states: IDLE and DUMP.
  - IDLE->DUMP: disp=1 with count>0. Snapshot rd_ptr=head and remaining=count; any wr in the same cycle is committed but excluded from the replay.
  - disp=1 with count==0: stays IDLE; done pulses the next cycle; no beats.
  - disp while in DUMP is ignored.
- Replay timing:
  - First out_vld rises the cycle after disp is sampled; out_dat is registered.
  - A beat transfers when out_vld&&out_rdy; the next beat may be valid the following cycle, giving full throughput with out_rdy held high.
  - While out_vld&&!out_rdy, out_dat and out_last hold stable.
  - out_last=1 exactly on beat number count_snapshot.
  - After the last transfer: out_vld=0 next cycle, done=1 for that one cycle, state returns to IDLE.
  - Replay is non-destructive: count, head and tail are unchanged afterwards.
- Replay order: entries head, head+1, ... wrapping mod DEPTH. After OVWR overwrites, this gives the newest DEPTH words in arrival order.
- clr=1:
  - Next cycle: count=0, head=tail=0, drop_cnt=0.
  - In DUMP, aborts immediately: out_vld/out_last drop the next cycle, no done pulse, state=IDLE.
  - clr has priority over wr and disp in the same cycle; the write is neither stored nor counted.
- rst mid-replay: same as reset; no done pulse.
- busy = (state==DUMP). full and count are registered and consistent with each other every cycle.

Test Plan:
- DEPTH=16: write the 11 bytes of "Hello World" back-to-back, pulse disp with out_rdy=1 -> count=11; beats 'H','e',...,'d' on consecutive cycles starting 1 cycle after disp; out_last on 'd'; done 1 cycle later; drop_cnt=0; count still 11.
- DEPTH=8, OVWR=0: write "Hello World" -> count=8, full=1, drop_cnt=3; replay yields "Hello Wo".
- DEPTH=8, OVWR=1: same writes -> drop_cnt=3; replay yields "lo World" (0x6C first, 0x64 last with out_last).
- Back-pressure: out_rdy toggles 1,0,0,1,... during an 11-beat replay -> out_dat stable during every stall; exactly 11 transfers in order; writes issued during replay dropped and drop_cnt incremented per write.
- Empty and abort: disp with count=0 -> done pulse, no out_vld. Assert clr on beat 4 of a replay -> out_vld low next cycle, no done, count=0.
- Simultaneous events: wr and disp in the same cycle with 5 stored -> replay emits 5 beats, count=6 afterwards. clr and wr together -> count=0, drop_cnt=0.
